// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the matrix-keypad scanner:
//   - special key codes (idle, '*', '#', '0')
//   - debounce FSM state encoding
//   - per-frame scan result encoding
//   - key_code(): maps a (row, column) position to its 4-bit key code
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'b1111;
    localparam logic [3:0] KEY_STAR = 4'b1010;
    localparam logic [3:0] KEY_HASH = 4'b1011;
    localparam logic [3:0] KEY_ZERO = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_e;

    // Rows 0-2 carry digits 1..9 (3*row + col + 1); row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] r4;
        r4 = {2'b00, row};
        if (row == 2'd3) begin
            case (col)
                2'd0:    return KEY_STAR;
                2'd1:    return KEY_ZERO;
                default: return KEY_HASH;
            endcase
        end
        return (r4 << 1) + r4 + {2'b00, col} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_frame_decode.sv
// ---------------------------------------------------------------------------
// keypad_frame_decode
// Collects the row samples of columns 0 and 1 and, on the column-2 sample,
// classifies the whole 4x3 frame.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   sample_en     : last cycle of a scan slot (rows are valid for col)
//   col           : column currently driven (0..2)
//   rows          : synchronized rows, active-low
//   frame_valid   : high on the column-2 sample cycle (frame end)
//   result        : NONE / SINGLE / MULTI for the frame
//   code          : key code when result is SINGLE, KEY_NONE otherwise
// ---------------------------------------------------------------------------
module keypad_frame_decode
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [1:0] col,
    input  logic [3:0] rows,
    output logic       frame_valid,
    output frame_res_e result,
    output logic [3:0] code
);

    logic [3:0] samp [2];

    // Columns 0 and 1 are stored; column 2 is used live on the frame-end cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_col
            logic [3:0] samp_q;
            logic [3:0] samp_d;

            always_comb begin
                samp_d = samp_q;
                if (sample_en && (col == 2'(gi)))
                    samp_d = rows;
            end

            always_ff @(posedge clk) begin
                if (!rst) samp_q <= 4'b1111;
                else      samp_q <= samp_d;
            end

            assign samp[gi] = samp_q;
        end
    endgenerate

    assign frame_valid = sample_en && (col == 2'd2);

    logic [3:0] cur [3];
    logic [3:0] low_cnt;
    logic [3:0] last_code;

    always_comb begin
        cur[0]    = samp[0];
        cur[1]    = samp[1];
        cur[2]    = rows;
        low_cnt   = 4'd0;
        last_code = KEY_NONE;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!cur[c][r]) begin
                    low_cnt   = low_cnt + 4'd1;
                    last_code = key_code(2'(r), 2'(c));
                end
            end
        end
    end

    always_comb begin
        result = RES_MULTI;
        code   = KEY_NONE;
        if (low_cnt == 4'd0) begin
            result = RES_NONE;
        end else if (low_cnt == 4'd1) begin
            result = RES_SINGLE;
            code   = last_code;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
// Scans a 4x3 phone keypad, rejects multi-key (ghost) frames and debounces
// presses and releases over DEBOUNCE_FRAMES whole frames.
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   row_in     : keypad rows, active-low, asynchronous
//   col_out    : column drive, one-hot-low
//   keypad_in  : debounced key code while held, 4'b1111 when idle
//   key_valid  : one-cycle pulse on an accepted press
//   key_held   : high while a debounced key is held
// Optional build macro KEYPAD_REPEAT_EN: auto-repeat key_valid while a key
// stays held (first repeat after 32 frames, then every 8 frames).
// ---------------------------------------------------------------------------
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] keypad_in,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_N     = 4'(DEBOUNCE_FRAMES);

    logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_q, col_d;
    state_e            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        deb_cnt_q, deb_cnt_d;
    logic [3:0]        keypad_in_q, keypad_in_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;
    logic              slot_last;
    logic              accept, release_key;

    logic              frame_valid;
    frame_res_e        frame_res;
    logic [3:0]        frame_code;

    // ---------------- synchronizer and scan timing ----------------
    assign slot_last = (slot_q == SLOT_LAST);

    always_comb begin
        sync1_d = row_in;
        sync2_d = sync1_q;
        slot_d  = slot_last ? '0 : slot_q + 1'b1;
        col_d   = col_q;
        if (slot_last)
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    end

    assign col_out = ~(3'b001 << col_q);

    keypad_frame_decode u_decode (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (slot_last),
        .col         (col_q),
        .rows        (sync2_q),
        .frame_valid (frame_valid),
        .result      (frame_res),
        .code        (frame_code)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            slot_q      <= '0;
            col_q       <= 2'd0;
            state_q     <= ST_IDLE;
            cand_q      <= KEY_NONE;
            deb_cnt_q   <= 4'd0;
            keypad_in_q <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            slot_q      <= slot_d;
            col_q       <= col_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            deb_cnt_q   <= deb_cnt_d;
            keypad_in_q <= keypad_in_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // ---------------- next-state logic ----------------
    // MULTI never matches a key, so it behaves exactly like NONE here.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        deb_cnt_d   = deb_cnt_q;
        accept      = 1'b0;
        release_key = 1'b0;
        if (frame_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        cand_d = frame_code;
                        if (DEB_N == 4'd1) begin
                            state_d   = ST_HELD;
                            deb_cnt_d = 4'd0;
                            accept    = 1'b1;
                        end else begin
                            state_d   = ST_PRESS_DEB;
                            deb_cnt_d = 4'd1;
                        end
                    end
                end
                ST_PRESS_DEB: begin
                    if (frame_res == RES_SINGLE && frame_code == cand_q) begin
                        if (deb_cnt_q + 4'd1 == DEB_N) begin
                            state_d   = ST_HELD;
                            deb_cnt_d = 4'd0;
                            accept    = 1'b1;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d   = ST_IDLE;
                        deb_cnt_d = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (frame_res == RES_SINGLE && frame_code == keypad_in_q) begin
                        deb_cnt_d = 4'd0;
                    end else if (deb_cnt_q + 4'd1 == DEB_N) begin
                        state_d     = ST_IDLE;
                        deb_cnt_d   = 4'd0;
                        release_key = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = 4'd0;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [5:0] rep_cnt_q, rep_cnt_d;
    logic       rep_pulse;

    // After the first repeat at 32 held frames, reload to 24 so the next
    // one lands 8 frames later.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_pulse = 1'b0;
        if (state_q == ST_HELD && frame_valid && frame_res == RES_SINGLE
            && frame_code == keypad_in_q) begin
            if (rep_cnt_q + 6'd1 == 6'd32) begin
                rep_pulse = 1'b1;
                rep_cnt_d = 6'd24;
            end else begin
                rep_cnt_d = rep_cnt_q + 6'd1;
            end
        end
        if (state_d != ST_HELD)
            rep_cnt_d = 6'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) rep_cnt_q <= 6'd0;
        else      rep_cnt_q <= rep_cnt_d;
    end
`endif

    // ---------------- output logic ----------------
    always_comb begin
        keypad_in_d = keypad_in_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        if (accept) begin
            keypad_in_d = frame_code;
            key_held_d  = 1'b1;
            key_valid_d = 1'b1;
        end else if (release_key) begin
            keypad_in_d = KEY_NONE;
            key_held_d  = 1'b0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (rep_pulse)
            key_valid_d = 1'b1;
`endif
    end

    assign keypad_in = keypad_in_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (one frame = 12 clocks). A behavioural keypad drives row_in from the set
// of pressed keys and the current col_out. Cycle numbering: cyc=k is the
// state sampled 1 time unit after the k-th rising edge following reset
// release; frame n is evaluated on edge 12n.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [3:0]  keypad_in;
    logic        key_valid;
    logic        key_held;

    logic [11:0] keys = 12'd0;   // bit r*3+c = key at row r, col c pressed

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcnt     = 0;
    int last_v   = -1;
    int dbl      = 0;
    logic prev_v = 1'b0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .keypad_in (keypad_in),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!col_out[c] && keys[r*3+c])
                    row_in[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s cyc=%0d value=0x%0h", tag, cyc, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (key_valid === 1'b1) begin
                vcnt++;
                last_v = cyc;
                if (prev_v) dbl++;
            end
            prev_v = key_valid;
        end
    endtask

    // Holds rst low for 3 edges, then releases it; cyc restarts at 0.
    task automatic do_reset();
        rst = 1'b0;
        tick(3);
        rst    = 1'b1;
        cyc    = 0;
        vcnt   = 0;
        last_v = -1;
        prev_v = 1'b0;
    endtask

    logic [11:0] tbl_key  [4];
    logic [3:0]  tbl_code [4];

    initial begin
        tbl_key[0] = 12'h010; tbl_code[0] = 4'd5;     // '5' r1c1
        tbl_key[1] = 12'h100; tbl_code[1] = 4'd9;     // '9' r2c2
        tbl_key[2] = 12'h200; tbl_code[2] = 4'b1010;  // '*' r3c0
        tbl_key[3] = 12'h400; tbl_code[3] = 4'b0000;  // '0' r3c1

        // ---- reset values and column rotation ----
        keys = 12'd0;
        rst  = 1'b0;
        tick(3);
        check("rst_col_out", 32'(col_out), 32'(3'b110));
        check("rst_keypad_in", 32'(keypad_in), 32'(4'b1111));
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        rst = 1'b1; cyc = 0;
        tick(3);
        check("rot_col0_end", 32'(col_out), 32'(3'b110));
        tick(1);
        check("rot_col1", 32'(col_out), 32'(3'b101));
        tick(4);
        check("rot_col2", 32'(col_out), 32'(3'b011));
        tick(4);
        check("rot_wrap", 32'(col_out), 32'(3'b110));

        // ---- clean press of '3', 5 frames, then release ----
        keys = 12'h004;
        do_reset();
        tick(35);
        check("p3_no_early_pulse", 32'(vcnt), 32'd0);
        check("p3_pre_code", 32'(keypad_in), 32'(4'b1111));
        tick(1);
        check("p3_valid_at_36", 32'(key_valid), 32'd1);
        check("p3_code", 32'(keypad_in), 32'(4'b0011));
        check("p3_held", 32'(key_held), 32'd1);
        tick(24);
        check("p3_single_pulse", 32'(vcnt), 32'd1);
        check("p3_pulse_cycle", 32'(last_v), 32'd36);
        check("p3_still_held", 32'(keypad_in), 32'(4'b0011));
        keys = 12'd0;
        tick(35);
        check("rel_before", 32'(keypad_in), 32'(4'b0011));
        tick(1);
        check("rel_code", 32'(keypad_in), 32'(4'b1111));
        check("rel_held", 32'(key_held), 32'd0);
        check("rel_no_pulse", 32'(vcnt), 32'd1);

        // ---- 2-frame dropout while holding '3' ----
        keys = 12'h004;
        do_reset();
        tick(36);
        check("drop_accept", 32'(keypad_in), 32'(4'b0011));
        keys = 12'd0;
        tick(24);
        keys = 12'h004;
        tick(48);
        check("drop_code_kept", 32'(keypad_in), 32'(4'b0011));
        check("drop_held_kept", 32'(key_held), 32'd1);
        check("drop_one_pulse", 32'(vcnt), 32'd1);

        // ---- bounce of '1': frames 1,2 present, 3 absent, then stable ----
        keys = 12'h001;
        do_reset();
        tick(24);
        keys = 12'd0;
        tick(12);
        keys = 12'h001;
        tick(35);
        check("bnc_no_pulse", 32'(vcnt), 32'd0);
        check("bnc_pre_code", 32'(keypad_in), 32'(4'b1111));
        tick(1);
        check("bnc_valid", 32'(key_valid), 32'd1);
        check("bnc_code", 32'(keypad_in), 32'(4'b0001));

        // ---- ghost '1'+'2', then '#' alone ----
        keys = 12'h003;
        do_reset();
        tick(72);
        check("ghost_no_pulse", 32'(vcnt), 32'd0);
        check("ghost_code", 32'(keypad_in), 32'(4'b1111));
        check("ghost_held", 32'(key_held), 32'd0);
        keys = 12'h800;
        tick(36);
        check("hash_valid", 32'(key_valid), 32'd1);
        check("hash_code", 32'(keypad_in), 32'(4'b1011));

        // ---- key map spot checks ----
        for (int i = 0; i < 4; i++) begin
            keys = tbl_key[i];
            do_reset();
            tick(36);
            check("map_valid", 32'(key_valid), 32'd1);
            check("map_code", 32'(keypad_in), 32'(tbl_code[i]));
        end

        // ---- reset in the middle of a press debounce ----
        keys = 12'h004;
        do_reset();
        tick(24);
        rst = 1'b0;
        tick(1);
        check("mid_rst_col_out", 32'(col_out), 32'(3'b110));
        check("mid_rst_code", 32'(keypad_in), 32'(4'b1111));
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_held", 32'(key_held), 32'd0);
        tick(2);
        rst = 1'b1; cyc = 0; vcnt = 0; prev_v = 1'b0;
        tick(35);
        check("mid_rst_no_early", 32'(vcnt), 32'd0);
        tick(1);
        check("mid_rst_full_deb", 32'(key_valid), 32'd1);

        check("no_double_pulse", 32'(dbl), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
